// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a single-outstanding-request instruction memory port
// and fills the IF/ID register, with a one-entry skid buffer and redirect handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ir,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        ir_valid,
    output logic        misalign_err
);

    typedef enum logic [1:0] {FETCH, SKID, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        ir_valid_q, ir_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] skid_insn_q, skid_insn_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] disc_addr_q, disc_addr_d;

    logic accept;
    logic rsp;
    logic load;

    assign imem_req  = !rst && (state_q != SKID);
    assign imem_addr = (state_q == DISCARD) ? disc_addr_q : pc_q;
    assign accept    = !stall || !ir_valid_q;
    // A response only counts while a request is actually being presented.
    assign rsp       = imem_req && imem_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        pc_out_d    = pc_out_q;
        pc_plus4_d  = pc_plus4_q;
        ir_valid_d  = ir_valid_q;
        misalign_d  = 1'b0;
        skid_insn_d = skid_insn_q;
        skid_pc_d   = skid_pc_q;
        disc_addr_d = disc_addr_q;
        load        = 1'b0;

        if (redirect) begin
            ir_d        = NOP_INSN;
            ir_valid_d  = 1'b0;
            skid_insn_d = 32'h0;
            skid_pc_d   = 32'h0;
            pc_d        = {redirect_pc[31:2], 2'b00};
            misalign_d  = |redirect_pc[1:0];
            case (state_q)
                FETCH: begin
                    // Request still in flight: hold its address until it drains.
                    if (!rsp) begin
                        state_d     = DISCARD;
                        disc_addr_d = pc_q;
                    end
                end
                SKID:    state_d = FETCH;
                DISCARD: if (rsp) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (rsp) begin
                        pc_d = pc_q + 32'd4;
                        if (accept) begin
                            load       = 1'b1;
                            ir_d       = imem_rdata;
                            pc_out_d   = pc_q;
                            pc_plus4_d = pc_q + 32'd4;
                            ir_valid_d = 1'b1;
                        end else begin
                            skid_insn_d = imem_rdata;
                            skid_pc_d   = pc_q;
                            state_d     = SKID;
                        end
                    end
                end
                SKID: begin
                    if (accept) begin
                        load        = 1'b1;
                        ir_d        = skid_insn_q;
                        pc_out_d    = skid_pc_q;
                        pc_plus4_d  = skid_pc_q + 32'd4;
                        ir_valid_d  = 1'b1;
                        skid_insn_d = 32'h0;
                        skid_pc_d   = 32'h0;
                        state_d     = FETCH;
                    end
                end
                DISCARD: if (rsp) state_d = FETCH;
                default: state_d = FETCH;
            endcase

            // Decode consumed ir and nothing replaced it: insert a bubble.
            if (!load && ir_valid_q && !stall) begin
                ir_d       = NOP_INSN;
                ir_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= NOP_INSN;
            pc_out_q    <= 32'h0;
            pc_plus4_q  <= 32'h0;
            ir_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            skid_insn_q <= 32'h0;
            skid_pc_q   <= 32'h0;
            disc_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            pc_out_q    <= pc_out_d;
            pc_plus4_q  <= pc_plus4_d;
            ir_valid_q  <= ir_valid_d;
            misalign_q  <= misalign_d;
            skid_insn_q <= skid_insn_d;
            skid_pc_q   <= skid_pc_d;
            disc_addr_q <= disc_addr_d;
        end
    end

    assign ir           = ir_q;
    assign pc_out       = pc_out_q;
    assign pc_plus4     = pc_plus4_q;
    assign ir_valid     = ir_valid_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a variable-latency instruction memory model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] ir, pc_out, pc_plus4;
    logic        ir_valid, misalign_err;

    int lat = 0;
    int cnt = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ir(ir), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .ir_valid(ir_valid), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : a + 32'h5500_0000;
    endfunction

    // Memory answers after lat idle request cycles; ready only while a request is seen.
    always @(negedge clk) begin
        if (rst) begin
            imem_ready = 1'b0;
            cnt = 0;
        end else begin
            if (imem_ready) cnt = 0;
            if (imem_req && cnt >= lat) begin
                imem_ready = 1'b1;
                imem_rdata = word(imem_addr);
            end else begin
                imem_ready = 1'b0;
                imem_rdata = 32'h0;
                if (imem_req) cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat_v);
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; lat = lat_v;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; lat = 0;
        tick(); tick();
        total_cnt++;
        if ({imem_req, ir, ir_valid, pc_out, pc_plus4, misalign_err} !== {1'b0, NOP, 1'b0, 32'h0, 32'h0, 1'b0})
            $display("FAIL reset_state: req=%b ir=%h v=%b pc_out=%h p4=%h mis=%b", imem_req, ir, ir_valid, pc_out, pc_plus4, misalign_err);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL first_req: req=%b addr=%h v=%b required 1/00000000/0", imem_req, imem_addr, ir_valid);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            tick();
            total_cnt++;
            if ({ir, ir_valid, pc_out, pc_plus4} !== {word(a), 1'b1, a, a + 32'd4})
                $display("FAIL stream_%0d: ir=%h v=%b pc_out=%h p4=%h required ir=%h pc_out=%h", i, ir, ir_valid, pc_out, pc_plus4, word(a), a);
            else pass_cnt++;
        end
    endtask

    task automatic test_skid();
        tick();
        stall = 1'b1;
        tick();
        total_cnt++;
        if ({imem_req, ir, ir_valid, pc_out} !== {1'b0, word(32'hC), 1'b1, 32'hC})
            $display("FAIL skid_enter: req=%b ir=%h v=%b pc_out=%h", imem_req, ir, ir_valid, pc_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({imem_req, ir, ir_valid, pc_out} !== {1'b0, word(32'hC), 1'b1, 32'hC})
            $display("FAIL skid_hold: req=%b ir=%h v=%b pc_out=%h", imem_req, ir, ir_valid, pc_out);
        else pass_cnt++;
        stall = 1'b0;
        tick();
        total_cnt++;
        if ({ir, ir_valid, pc_out, pc_plus4, imem_req, imem_addr} !== {32'hDEAD_BEEF, 1'b1, 32'h10, 32'h14, 1'b1, 32'h14})
            $display("FAIL skid_drain: ir=%h v=%b pc_out=%h p4=%h req=%b addr=%h", ir, ir_valid, pc_out, pc_plus4, imem_req, imem_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({ir, pc_out} !== {word(32'h14), 32'h14})
            $display("FAIL skid_resume: ir=%h pc_out=%h required %h/00000014", ir, pc_out, word(32'h14));
        else pass_cnt++;
    endtask

    task automatic test_redirect_discard();
        do_reset(2);
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        total_cnt++;
        if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL discard_hold0: req=%b addr=%h v=%b", imem_req, imem_addr, ir_valid);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if ({imem_addr, ir, ir_valid} !== {32'h20, NOP, 1'b0})
            $display("FAIL discard_to20: addr=%h ir=%h v=%b", imem_addr, ir, ir_valid);
        else pass_cnt++;
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        total_cnt++;
        if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'h20, 1'b0})
            $display("FAIL discard_hold20: req=%b addr=%h v=%b", imem_req, imem_addr, ir_valid);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if ({imem_addr, ir, ir_valid} !== {32'h100, NOP, 1'b0})
            $display("FAIL discard_drop20: addr=%h ir=%h v=%b required 00000100/%h/0", imem_addr, ir, ir_valid, NOP);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (ir_valid !== 1'b0)
                $display("FAIL discard_wait_%0d: ir_valid=%b required 0", i, ir_valid);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({ir, ir_valid, pc_out, pc_plus4} !== {word(32'h100), 1'b1, 32'h100, 32'h104})
            $display("FAIL discard_arrive: ir=%h v=%b pc_out=%h p4=%h", ir, ir_valid, pc_out, pc_plus4);
        else pass_cnt++;
    endtask

    task automatic test_redirect_ready_stall();
        do_reset(0);
        tick();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        total_cnt++;
        if ({ir, ir_valid, imem_req, imem_addr} !== {NOP, 1'b0, 1'b1, 32'h40})
            $display("FAIL redir_ready_stall: ir=%h v=%b req=%b addr=%h", ir, ir_valid, imem_req, imem_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({ir, ir_valid, pc_out} !== {word(32'h40), 1'b1, 32'h40})
            $display("FAIL redir_first_word: ir=%h v=%b pc_out=%h", ir, ir_valid, pc_out);
        else pass_cnt++;
        stall = 1'b0;
    endtask

    task automatic test_misalign();
        redirect = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect = 1'b0;
        total_cnt++;
        if ({imem_addr, misalign_err, ir_valid} !== {32'h200, 1'b1, 1'b0})
            $display("FAIL misalign_pulse: addr=%h mis=%b v=%b required 00000200/1/0", imem_addr, misalign_err, ir_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({misalign_err, ir, pc_out} !== {1'b0, word(32'h200), 32'h200})
            $display("FAIL misalign_clear: mis=%b ir=%h pc_out=%h", misalign_err, ir, pc_out);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        total_cnt++;
        if ({imem_addr, misalign_err} !== {32'hFFFF_FFFC, 1'b0})
            $display("FAIL wrap_redirect: addr=%h mis=%b", imem_addr, misalign_err);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({ir, pc_out, pc_plus4, imem_addr} !== {32'h54FF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0})
            $display("FAIL wrap_pc: ir=%h pc_out=%h p4=%h addr=%h", ir, pc_out, pc_plus4, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_bubble();
        lat = 5;
        tick();
        total_cnt++;
        if ({ir, ir_valid, imem_req, imem_addr} !== {NOP, 1'b0, 1'b1, 32'h0})
            $display("FAIL bubble: ir=%h v=%b req=%b addr=%h", ir, ir_valid, imem_req, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        bit got;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (imem_req !== 1'b0)
            $display("FAIL rst_req_low: req=%b required 0", imem_req);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({ir, ir_valid, pc_out, pc_plus4, misalign_err} !== {NOP, 1'b0, 32'h0, 32'h0, 1'b0})
            $display("FAIL rst_midflight: ir=%h v=%b pc_out=%h p4=%h", ir, ir_valid, pc_out, pc_plus4);
        else pass_cnt++;
        lat = 1;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0})
            $display("FAIL rst_restart: req=%b addr=%h required 1/00000000", imem_req, imem_addr);
        else pass_cnt++;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (ir_valid) got = 1'b1;
        end
        total_cnt++;
        if ({got, ir, pc_out} !== {1'b1, word(32'h0), 32'h0})
            $display("FAIL rst_first_word: seen=%b ir=%h pc_out=%h required 1/%h/00000000", got, ir, pc_out, word(32'h0));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_redirect_discard();
        test_redirect_ready_stall();
        test_misalign();
        test_wrap();
        test_bubble();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
